// File: rtl/line_mem_pkg.sv
// line_mem_pkg: shared types and defaults for the line memory responder.
// Holds FSM state encoding, default line/address widths and latency counter width.
package line_mem_pkg;

    localparam int LINE_W      = 64;
    localparam int LINE_ADDR_W = 14;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef logic [CNT_W-1:0] cnt_t;

    // Saturating 16-bit increment for the statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/line_mem_responder_if.sv
// line_mem_responder_if: cache-controller <-> main-memory line bus.
// master: re/we/addr/wdata out; slave: rd_data/rdy/busy/rd_cnt/wr_cnt out.
interface line_mem_responder_if #(
    parameter int LINE_ADDR_W = line_mem_pkg::LINE_ADDR_W,
    parameter int LINE_W      = line_mem_pkg::LINE_W
);
    logic                   re;
    logic                   we;
    logic [LINE_ADDR_W-1:0] addr;
    logic [LINE_W-1:0]      wdata;
    logic [LINE_W-1:0]      rd_data;
    logic                   rdy;
    logic                   busy;
    logic [15:0]            rd_cnt;
    logic [15:0]            wr_cnt;

    modport master (
        output re, we, addr, wdata,
        input  rd_data, rdy, busy, rd_cnt, wr_cnt
    );

    modport slave (
        input  re, we, addr, wdata,
        output rd_data, rdy, busy, rd_cnt, wr_cnt
    );

endinterface

// File: rtl/line_mem_array.sv
// line_mem_array: single-port 2**DEPTH_LOG2 x LINE_W line storage.
// Ports: clk, rst (clears read register only), we, re, idx, wdata, rdata (registered).
module line_mem_array #(
    parameter int LINE_W     = 64,
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [LINE_W-1:0]     wdata,
    output logic [LINE_W-1:0]     rdata
);

    logic [LINE_W-1:0] mem [2**DEPTH_LOG2];
    logic [LINE_W-1:0] q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Write-first: a write returns the new line on the read register,
    // so a combined read/write sees the freshly written data.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= wdata;
        end else if (re) begin
            q <= mem[idx];
        end
    end

    assign rdata = q;

endmodule

// File: rtl/line_mem_responder.sv
// line_mem_responder: fixed-latency line read/write responder (IDLE/BUSY/DONE).
// Ports: clk, rst (sync, active high), bus (slave); LINE_MEM_STATS_EN builds rd/wr counters.
module line_mem_responder #(
    parameter int LINE_ADDR_W = line_mem_pkg::LINE_ADDR_W,
    parameter int LINE_W      = line_mem_pkg::LINE_W,
    parameter int DEPTH_LOG2  = 14,
    parameter int LATENCY     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    line_mem_responder_if.slave  bus
);
    import line_mem_pkg::*;

    localparam cnt_t LOAD = cnt_t'(LATENCY - 1);
    localparam bit   FAST = (LATENCY == 1);

    state_e                state;
    cnt_t                  cnt;
    logic                  op_wr;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [LINE_W-1:0]     wdata_q;
    logic                  rdy_q;
    logic                  busy_q;

    logic                  req;
    logic                  idle;
    logic                  commit;
    logic                  arr_wr_op;
    logic [DEPTH_LOG2-1:0] arr_idx;
    logic [LINE_W-1:0]     arr_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic [LINE_W-1:0]     arr_rdata;

    assign req  = bus.re | bus.we;
    assign idle = (state == ST_IDLE);

    // Commit happens on the edge entering DONE. With LATENCY=1 that edge
    // is the accept edge itself, so the live bus values are used.
    assign commit = ~rst & ((idle & req & FAST) |
                            ((state == ST_BUSY) & (cnt == '0)));

    assign arr_wr_op = idle ? bus.we                     : op_wr;
    assign arr_idx   = idle ? bus.addr[DEPTH_LOG2-1:0]  : idx_q;
    assign arr_wdata = idle ? bus.wdata                  : wdata_q;

    assign mem_we = commit & arr_wr_op;
    assign mem_re = commit & ~arr_wr_op;

    line_mem_array #(
        .LINE_W     (LINE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (arr_idx),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            op_wr   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    rdy_q <= 1'b0;
                    if (req) begin
                        op_wr   <= bus.we;
                        idx_q   <= bus.addr[DEPTH_LOG2-1:0];
                        wdata_q <= bus.wdata;
                        cnt     <= LOAD;
                        busy_q  <= 1'b1;
                        if (FAST) begin
                            state <= ST_DONE;
                            rdy_q <= 1'b1;
                        end else begin
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state <= ST_DONE;
                        rdy_q <= 1'b1;
                    end else begin
                        cnt <= cnt - cnt_t'(1);
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    rdy_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    rdy_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data = arr_rdata;
    assign bus.rdy     = rdy_q;
    assign bus.busy    = busy_q;

`ifdef LINE_MEM_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (mem_re) begin
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end
            if (mem_we) begin
                wr_cnt_q <= sat_inc(wr_cnt_q);
            end
        end
    end

    assign bus.rd_cnt = rd_cnt_q;
    assign bus.wr_cnt = wr_cnt_q;
`else
    assign bus.rd_cnt = 16'd0;
    assign bus.wr_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: directed stimulus with a scoreboard queue and
// a negedge monitor that pops one expectation per rdy pulse.
module tb_line_mem_responder;

    localparam int AW  = 14;
    localparam int LW  = 64;
    localparam int DL  = 4;
    localparam int LAT = 4;

    typedef struct {
        logic        chk;
        logic [63:0] data;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   exp_rd = 0;
    int   exp_wr = 0;
    exp_t sb[$];

    line_mem_responder_if #(.LINE_ADDR_W(AW), .LINE_W(LW)) bus();

    line_mem_responder #(
        .LINE_ADDR_W (AW),
        .LINE_W      (LW),
        .DEPTH_LOG2  (DL),
        .LATENCY     (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_stats(input string name);
`ifdef LINE_MEM_STATS_EN
        check({name, "_rd_cnt"}, 64'(bus.rd_cnt), 64'(exp_rd));
        check({name, "_wr_cnt"}, 64'(bus.wr_cnt), 64'(exp_wr));
`else
        check({name, "_rd_cnt"}, 64'(bus.rd_cnt), 64'd0);
        check({name, "_wr_cnt"}, 64'(bus.wr_cnt), 64'd0);
`endif
    endtask

    // Monitor: every rdy cycle consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rdy === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rdy: got rdy=1 want no rdy (t=%0t)",
                             $time);
                end else begin
                    e = sb.pop_front();
                    if (e.chk) begin
                        check(e.name, bus.rd_data, e.data);
                    end
                end
            end
        end
    end

    // One complete request; checks rdy latency, pulse width and busy span.
    task automatic op(input logic re_i, input logic we_i,
                      input logic [AW-1:0] a, input logic [63:0] d,
                      input logic chk, input logic [63:0] exp_data,
                      input string name);
        int first;
        int n_rdy;
        int n_busy;
        @(negedge clk);
        bus.re    = re_i;
        bus.we    = we_i;
        bus.addr  = a;
        bus.wdata = d;
        sb.push_back('{chk, exp_data, name});
        if (we_i) exp_wr++;
        else      exp_rd++;
        @(posedge clk);
        first  = -1;
        n_rdy  = 0;
        n_busy = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n == 0) begin
                bus.re = 1'b0;
                bus.we = 1'b0;
            end
            if (bus.rdy === 1'b1) begin
                n_rdy++;
                if (first < 0) first = n;
            end
            if (bus.busy === 1'b1) n_busy++;
        end
        check({name, "_rdy_cycle"}, 64'(first), 64'(LAT));
        check({name, "_rdy_width"}, 64'(n_rdy), 64'd1);
        check({name, "_busy_len"}, 64'(n_busy), 64'(LAT + 1));
        check_stats(name);
    endtask

    initial begin
        bus.re    = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", 64'(bus.rdy), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_rd_data", bus.rd_data, 64'd0);
        check("rst_rd_cnt", 64'(bus.rd_cnt), 64'd0);
        check("rst_wr_cnt", 64'(bus.wr_cnt), 64'd0);
        rst = 1'b0;

        // Basic write then read-back.
        op(1'b0, 1'b1, 14'h0010, 64'h0004_0003_0002_0001,
           1'b0, 64'd0, "wr_10");
        op(1'b1, 1'b0, 14'h0010, 64'd0,
           1'b1, 64'h0004_0003_0002_0001, "rd_10");

        // re held high: rdy at 4, 10, 16 after the first accept edge.
        // 14'h0020 aliases to index 0, the same line as 14'h0010.
        @(negedge clk);
        bus.re   = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 14'h0020;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{1'b1, 64'h0004_0003_0002_0001, "held_data"});
        end
        exp_rd += 3;
        @(posedge clk);
        for (int n = 0; n < 22; n++) begin
            @(negedge clk);
            check($sformatf("held_rdy_c%0d", n), 64'(bus.rdy),
                  64'((n == 4 || n == 10 || n == 16) ? 1 : 0));
            if (n == 16) bus.re = 1'b0;
        end
        check_stats("held");

        // re and we together: write wins, DONE shows the new line.
        op(1'b1, 1'b1, 14'h0005, 64'hDEAD_BEEF_CAFE_F00D,
           1'b1, 64'hDEAD_BEEF_CAFE_F00D, "rw_05");

        // Aliasing with DEPTH_LOG2=4.
        op(1'b0, 1'b1, 14'h0003, 64'h1111, 1'b0, 64'd0, "wr_03");
        op(1'b1, 1'b0, 14'h0013, 64'd0, 1'b1, 64'h1111, "rd_13_alias");

        // Reset during BUSY aborts the second write.
        op(1'b0, 1'b1, 14'h0007, 64'hAAAA, 1'b0, 64'd0, "wr_07_a");
        @(negedge clk);
        bus.we    = 1'b1;
        bus.addr  = 14'h0007;
        bus.wdata = 64'hBBBB;
        @(posedge clk);
        @(negedge clk);
        bus.we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_rd = 0;
        exp_wr = 0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_rdy", 64'(bus.rdy), 64'd0);
        check("abort_rd_data", bus.rd_data, 64'd0);
        check_stats("abort");
        repeat (8) @(negedge clk);
        check("abort_idle_busy", 64'(bus.busy), 64'd0);
        op(1'b1, 1'b0, 14'h0007, 64'd0, 1'b1, 64'hAAAA, "rd_07_kept");

        // Statistics after a further two reads: three reads since reset.
        op(1'b1, 1'b0, 14'h0005, 64'd0, 1'b1,
           64'hDEAD_BEEF_CAFE_F00D, "rd_05");
        op(1'b1, 1'b0, 14'h0003, 64'd0, 1'b1, 64'h1111, "rd_03");
`ifdef LINE_MEM_STATS_EN
        check("stats_rd3", 64'(bus.rd_cnt), 64'd3);
`else
        check("stats_rd3", 64'(bus.rd_cnt), 64'd0);
`endif
        check("stats_wr0", 64'(bus.wr_cnt), 64'd0);

        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
